// File: rtl/conv_writeback.sv
// conv_writeback - write-back stage behind the Conv block.
//
// Lines up the Conv input-valid strobe with Conv's output latency, then turns
// each aligned result into one BRAM write. Writes go to consecutive addresses
// starting at a base latched on start, for a length also latched on start.
// When the last result has been written the block pulses o_done.
//
// Optional feature (compile-time macro WB_PRIME_SKIP_EN):
//   defined   - after each start the first M_LEN-1 aligned results, which come
//               from a kernel window that is not yet filled, are dropped
//               silently inside RUN.
//   undefined - every aligned result in RUN is written; no skip logic exists.
//
// Ports:
//   CLK100MHZ     in   system clock, rising edge
//   i_reset       in   asynchronous active-low reset
//   i_start       in   one-cycle pulse that begins a segment
//   i_base_addr   in   first write address (latched on start)
//   i_n_words     in   number of results to write (latched on start)
//   i_conv_valid  in   the same strobe that drives Conv i_valid
//   i_conv_data   in   Conv o_data
//   o_wrEnable    out  BRAM write enable
//   o_writeAdd    out  BRAM write address
//   o_data        out  BRAM write data
//   o_busy        out  high while a segment is running
//   o_done        out  one-cycle pulse at the end of a segment
//   o_overrun     out  sticky flag: aligned result arrived outside RUN
module conv_writeback #(
  parameter int RAM_WIDTH  = 13,
  parameter int NB_ADDRESS = 10,
  parameter int CONV_LAT   = 2,
  parameter int M_LEN      = 3
) (
  input  logic                  CLK100MHZ,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [NB_ADDRESS-1:0] i_base_addr,
  input  logic [NB_ADDRESS-1:0] i_n_words,
  input  logic                  i_conv_valid,
  input  logic [RAM_WIDTH-1:0]  i_conv_data,
  output logic                  o_wrEnable,
  output logic [NB_ADDRESS-1:0] o_writeAdd,
  output logic [RAM_WIDTH-1:0]  o_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overrun
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  // Stage 0 captures the strobe on the same edge Conv samples it; CONV_LAT
  // further stages bring it level with the cycle in which Conv o_data is
  // stable, so the output registers capture valid and data together.
  logic [CONV_LAT:0] vld_dly;
  logic              aligned_valid;

  logic [NB_ADDRESS-1:0] base_q, base_d;
  logic [NB_ADDRESS-1:0] len_q, len_d;
  logic [NB_ADDRESS-1:0] count_q, count_d;
  logic                  wr_en_d;
  logic [NB_ADDRESS-1:0] addr_d;
  logic [RAM_WIDTH-1:0]  data_d;
  logic                  busy_d;
  logic                  done_d;
  logic                  ovr_d;
  logic                  write_ok;

  assign aligned_valid = vld_dly[CONV_LAT];

`ifdef WB_PRIME_SKIP_EN
  localparam int SKIP_W = (M_LEN > 1) ? $clog2(M_LEN) : 1;
  localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(M_LEN - 1);

  logic [SKIP_W-1:0] skip_q, skip_d;

  // Results are only written once the priming results have been discarded.
  assign write_ok = (skip_q == '0);

  always_ff @(posedge CLK100MHZ or negedge i_reset) begin
    if (!i_reset) begin
      skip_q <= '0;
    end else begin
      skip_q <= skip_d;
    end
  end

  always_comb begin
    skip_d = skip_q;
    if (state == IDLE && i_start) begin
      skip_d = SKIP_INIT;
    end else if (state == RUN && aligned_valid && skip_q != '0) begin
      skip_d = skip_q - 1'b1;
    end
  end
`else
  assign write_ok = 1'b1;
`endif

  // The delay line free-runs in every state so alignment survives start,
  // completion and overrun.
  always_ff @(posedge CLK100MHZ or negedge i_reset) begin
    if (!i_reset) begin
      vld_dly <= '0;
    end else begin
      vld_dly <= {vld_dly[CONV_LAT-1:0], i_conv_valid};
    end
  end

  always_ff @(posedge CLK100MHZ or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge i_reset) begin
    if (!i_reset) begin
      base_q     <= '0;
      len_q      <= '0;
      count_q    <= '0;
      o_wrEnable <= 1'b0;
      o_writeAdd <= '0;
      o_data     <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      base_q     <= base_d;
      len_q      <= len_d;
      count_q    <= count_d;
      o_wrEnable <= wr_en_d;
      o_writeAdd <= addr_d;
      o_data     <= data_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
      o_overrun  <= ovr_d;
    end
  end

  always_comb begin
    state_next = state;
    base_d     = base_q;
    len_d      = len_q;
    count_d    = count_q;
    wr_en_d    = 1'b0;
    addr_d     = o_writeAdd;
    data_d     = o_data;
    done_d     = 1'b0;
    ovr_d      = o_overrun;

    case (state)
      IDLE: begin
        if (i_start) begin
          base_d     = i_base_addr;
          len_d      = i_n_words;
          count_d    = '0;
          ovr_d      = 1'b0;
          state_next = (i_n_words == '0) ? DONE : RUN;
        end
        // A result landing together with start still belongs to no segment,
        // so setting the flag wins over the clear from start.
        if (aligned_valid) begin
          ovr_d = 1'b1;
        end
      end

      RUN: begin
        if (aligned_valid && write_ok) begin
          wr_en_d = 1'b1;
          addr_d  = base_q + count_q;
          data_d  = i_conv_data;
          count_d = count_q + 1'b1;
          if (count_q == len_q - 1'b1) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        done_d     = 1'b1;
        state_next = IDLE;
        if (aligned_valid) begin
          ovr_d = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_d = (state_next == RUN);
  end

endmodule

// File: tb/tb_conv_writeback.sv
// Testbench for conv_writeback (default build, CONV_LAT = 2).
//
// A small Conv model delays each valid's data by the Conv latency so that the
// data seen on i_conv_data matches the strobe the DUT re-aligns. Stimulus is a
// table of per-cycle records plus a few hand-written multi-cycle sequences.
module tb_conv_writeback;

  localparam int RAM_WIDTH  = 13;
  localparam int NB_ADDRESS = 10;
  localparam int CONV_LAT   = 2;
  localparam int M_LEN      = 3;
  localparam logic [RAM_WIDTH-1:0] JUNK = 13'h1555;

  logic                  CLK100MHZ;
  logic                  i_reset;
  logic                  i_start;
  logic [NB_ADDRESS-1:0] i_base_addr;
  logic [NB_ADDRESS-1:0] i_n_words;
  logic                  i_conv_valid;
  logic [RAM_WIDTH-1:0]  i_conv_data;
  logic                  o_wrEnable;
  logic [NB_ADDRESS-1:0] o_writeAdd;
  logic [RAM_WIDTH-1:0]  o_data;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_overrun;

  logic [RAM_WIDTH-1:0]  drive_data;
  logic [RAM_WIDTH-1:0]  conv_pipe [0:CONV_LAT];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic                  start;
    logic [NB_ADDRESS-1:0] base;
    logic [NB_ADDRESS-1:0] n;
    logic                  valid;
    logic [RAM_WIDTH-1:0]  data;
    logic                  we;
    logic [NB_ADDRESS-1:0] addr;
    logic [RAM_WIDTH-1:0]  wdata;
    logic                  busy;
    logic                  done;
    logic                  ovr;
  } vec_t;

  vec_t vecs[$];

  conv_writeback #(
    .RAM_WIDTH (RAM_WIDTH),
    .NB_ADDRESS(NB_ADDRESS),
    .CONV_LAT  (CONV_LAT),
    .M_LEN     (M_LEN)
  ) dut (
    .CLK100MHZ   (CLK100MHZ),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_n_words   (i_n_words),
    .i_conv_valid(i_conv_valid),
    .i_conv_data (i_conv_data),
    .o_wrEnable  (o_wrEnable),
    .o_writeAdd  (o_writeAdd),
    .o_data      (o_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_overrun   (o_overrun)
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  // Conv model: data for a valid sampled at edge N is stable after edge
  // N+CONV_LAT; slots without a valid carry junk so misalignment shows up.
  always @(posedge CLK100MHZ) begin
    conv_pipe[0] <= i_conv_valid ? drive_data : JUNK;
    for (int k = 1; k <= CONV_LAT; k++) begin
      conv_pipe[k] <= conv_pipe[k-1];
    end
  end
  assign i_conv_data = conv_pipe[CONV_LAT];

  task automatic checkVal(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic we,
                             input logic [NB_ADDRESS-1:0] addr,
                             input logic [RAM_WIDTH-1:0] wdata,
                             input logic busy, input logic done, input logic ovr);
    checkVal({tag, " wrEnable"}, 16'(o_wrEnable), 16'(we));
    if (we) begin
      checkVal({tag, " writeAdd"}, 16'(o_writeAdd), 16'(addr));
      checkVal({tag, " data"}, 16'(o_data), 16'(wdata));
    end
    checkVal({tag, " busy"}, 16'(o_busy), 16'(busy));
    checkVal({tag, " done"}, 16'(o_done), 16'(done));
    checkVal({tag, " overrun"}, 16'(o_overrun), 16'(ovr));
  endtask

  // Drives one cycle of inputs at the falling edge, lets the rising edge
  // sample them and returns at the next falling edge for checking.
  task automatic applyStimulus(input logic start, input logic [NB_ADDRESS-1:0] base,
                               input logic [NB_ADDRESS-1:0] n, input logic valid,
                               input logic [RAM_WIDTH-1:0] data);
    i_start      = start;
    i_base_addr  = base;
    i_n_words    = n;
    i_conv_valid = valid;
    drive_data   = data;
    @(posedge CLK100MHZ);
    @(negedge CLK100MHZ);
  endtask

  task automatic addVec(input logic start, input int base, input int n,
                        input logic valid, input int data, input logic we,
                        input int addr, input int wdata, input logic busy,
                        input logic done, input logic ovr);
    vec_t v;
    v.start = start;  v.base = NB_ADDRESS'(base); v.n = NB_ADDRESS'(n);
    v.valid = valid;  v.data = RAM_WIDTH'(data);
    v.we = we;        v.addr = NB_ADDRESS'(addr); v.wdata = RAM_WIDTH'(wdata);
    v.busy = busy;    v.done = done;              v.ovr = ovr;
    vecs.push_back(v);
  endtask

  initial begin
    int writes;

    i_reset      = 1'b0;
    i_start      = 1'b0;
    i_base_addr  = '0;
    i_n_words    = '0;
    i_conv_valid = 1'b0;
    drive_data   = '0;

    // Overrun probe: lone valid with no start flags overrun CONV_LAT+1 edges later.
    addVec(0, 0, 0, 1, 'h0AA, 0, 0, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 1);
    // Basic segment: base 0, four back-to-back results; start clears overrun.
    addVec(1, 0, 4, 0, 0,     0, 0, 0,     1, 0, 0);
    addVec(0, 0, 0, 1, 'h07F, 0, 0, 0,     1, 0, 0);
    addVec(0, 0, 0, 1, 'h07F, 0, 0, 0,     1, 0, 0);
    addVec(0, 0, 0, 1, 'h07E, 0, 0, 0,     1, 0, 0);
    addVec(0, 0, 0, 1, 'h07F, 1, 0, 'h07F, 1, 0, 0);
    addVec(0, 0, 0, 0, 0,     1, 1, 'h07F, 1, 0, 0);
    addVec(0, 0, 0, 0, 0,     1, 2, 'h07E, 1, 0, 0);
    addVec(0, 0, 0, 0, 0,     1, 3, 'h07F, 0, 0, 0);
    addVec(0, 0, 0, 0, 0,     0, 0, 0,     0, 1, 0);
    addVec(0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0);
    // Gapped valids with address wrap: 0x3FE, 0x3FF, 0x000.
    addVec(1, 'h3FE, 3, 0, 0,  0, 0,     0,     1, 0, 0);
    addVec(0, 0, 0, 1, 'h101,  0, 0,     0,     1, 0, 0);
    addVec(0, 0, 0, 0, 0,      0, 0,     0,     1, 0, 0);
    addVec(0, 0, 0, 0, 0,      0, 0,     0,     1, 0, 0);
    addVec(0, 0, 0, 1, 'h102,  1, 'h3FE, 'h101, 1, 0, 0);
    addVec(0, 0, 0, 0, 0,      0, 0,     0,     1, 0, 0);
    addVec(0, 0, 0, 0, 0,      0, 0,     0,     1, 0, 0);
    addVec(0, 0, 0, 1, 'h103,  1, 'h3FF, 'h102, 1, 0, 0);
    addVec(0, 0, 0, 0, 0,      0, 0,     0,     1, 0, 0);
    addVec(0, 0, 0, 0, 0,      0, 0,     0,     1, 0, 0);
    addVec(0, 0, 0, 0, 0,      1, 'h000, 'h103, 0, 0, 0);
    addVec(0, 0, 0, 0, 0,      0, 0,     0,     0, 1, 0);
    addVec(0, 0, 0, 0, 0,      0, 0,     0,     0, 0, 0);
    // Zero length: done one cycle after start, never busy, never writes.
    addVec(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] reset hold with valid toggling");
    @(negedge CLK100MHZ);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(0, 0, 0, c[0], 13'h0FF);
      checkOutput($sformatf("reset%0d", c), 0, 0, 0, 0, 0, 0);
    end
    i_reset = 1'b1;

    $display("[TB] table vectors");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].start, vecs[i].base, vecs[i].n, vecs[i].valid, vecs[i].data);
      checkOutput($sformatf("row%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                  vecs[i].busy, vecs[i].done, vecs[i].ovr);
    end

    $display("[TB] start ignored during RUN");
    writes = 0;
    for (int c = 0; c < 12; c++) begin
      logic st;
      logic [NB_ADDRESS-1:0] b;
      logic [NB_ADDRESS-1:0] n;
      st = (c == 0) || (c == 2);
      b  = (c == 2) ? 10'h100 : 10'h020;
      n  = (c == 2) ? 10'd2 : 10'd5;
      applyStimulus(st, b, n, (c >= 1 && c <= 5), 13'(12'h200 + c - 1));
      if (o_wrEnable) writes++;
      checkOutput($sformatf("ign%0d", c), (c >= 4 && c <= 8), 10'(10'h020 + c - 4),
                  13'(12'h200 + c - 4), (c <= 7), (c == 9), 1'b0);
    end
    checkVal("ign write count", 16'(writes), 16'd5);

    $display("[TB] reset in the middle of a segment");
    for (int c = 0; c < 6; c++) begin
      applyStimulus(c == 0, 10'h040, 10'd6, (c >= 1), 13'(12'h300 + c - 1));
      checkOutput($sformatf("mid%0d", c), (c >= 4), 10'(10'h040 + c - 4),
                  13'(12'h300 + c - 4), 1'b1, 1'b0, 1'b0);
    end
    i_reset      = 1'b0;
    i_start      = 1'b0;
    i_conv_valid = 1'b0;
    #1;
    checkOutput("midrst async", 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput($sformatf("midrst hold%0d", c), 0, 0, 0, 0, 0, 0);
    end
    i_reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput($sformatf("midrst idle%0d", c), 0, 0, 0, 0, 0, 0);
    end
    for (int c = 0; c < 8; c++) begin
      logic [RAM_WIDTH-1:0] d;
      d = (c == 1) ? 13'h011 : 13'h022;
      applyStimulus(c == 0, 10'h010, 10'd2, (c == 1 || c == 2), d);
      checkOutput($sformatf("after%0d", c), (c == 4 || c == 5), 10'(10'h010 + c - 4),
                  (c == 4) ? 13'h011 : 13'h022, (c <= 4), (c == 6), 1'b0);
    end

    $display("[TB] more results than length");
    for (int c = 0; c < 10; c++) begin
      applyStimulus(c == 0, 10'h080, 10'd3, (c >= 1 && c <= 5), 13'(c));
`ifdef WB_PRIME_SKIP_EN
      checkOutput($sformatf("extra%0d", c), (c >= 6 && c <= 8), 10'(10'h080 + c - 6),
                  13'(c - 3), (c <= 7), (c == 9), 1'b0);
`else
      checkOutput($sformatf("extra%0d", c), (c >= 4 && c <= 6), 10'(10'h080 + c - 4),
                  13'(c - 3), (c <= 5), (c == 7), (c >= 7));
`endif
    end

    $display("[TB] start coinciding with an aligned result");
    for (int c = 0; c < 4; c++) begin
      applyStimulus(c == 3, 10'h200, 10'd1, (c == 0), 13'h0AB);
    end
    checkVal("coincide busy", 16'(o_busy), 16'd1);
    checkVal("coincide overrun", 16'(o_overrun), 16'd1);
    checkVal("coincide wrEnable", 16'(o_wrEnable), 16'd0);
    i_reset = 1'b0;
    #1;
    checkOutput("final reset", 0, 0, 0, 0, 0, 0);
    @(negedge CLK100MHZ);
    i_reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
